// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter phase decoder:
// FSM state encoding, the legal code for each phase, and the phase-index width.
package johnson_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  function automatic int phase_w(input int n);
    return $clog2(2 * n);
  endfunction

  // Phases 0..n fill ones from the LSB; phases n+1..2n-1 clear them from the LSB.
  function automatic logic [63:0] johnson_code(input int idx, input int n);
    logic [63:0] all_ones;
    all_ones = (64'd1 << n) - 64'd1;
    if (idx <= n) begin
      return (64'd1 << idx) - 64'd1;
    end
    return all_ones & ~((64'd1 << (idx - n)) - 64'd1);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational decode of a Johnson counter word into a phase index,
// plus a legality flag (word must equal the canonical code for that index).
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int N = 4,
  parameter int W = phase_w(N)
) (
  input  logic [N-1:0] jc,
  output logic [W-1:0] idx,
  output logic         legal
);

  logic [W-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + W'(jc[i]);
    end
    // Upper half of the cycle (MSB set) counts down from 2N as ones are cleared.
    idx   = jc[N-1] ? (W'(2 * N) - ones) : ones;
    legal = (johnson_code(int'(idx), N) == {{(64 - N){1'b0}}, jc});
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder: legality check, phase tracking FSM, sticky errors.
// Revolution tick/counter is built only when JOHNSON_DEC_REVCNT_EN is defined.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int REV_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            jc_in,
  input  logic                    jc_valid,
  input  logic                    err_clr,
  output logic [$clog2(2*N)-1:0]  phase_idx,
  output logic [2*N-1:0]          phase_oh,
  output logic                    phase_valid,
  output logic                    code_err,
  output logic                    seq_err,
  output logic                    rev_tick,
  output logic [REV_W-1:0]        rev_cnt
);

  localparam int PW = $clog2(2 * N);
  localparam logic [PW-1:0] LAST = PW'(2 * N - 1);
  localparam logic [2*N-1:0] OH_ONE = {{(2 * N - 1){1'b0}}, 1'b1};

  state_t          state_reg;
  logic [PW-1:0]   phase_idx_reg;
  logic [2*N-1:0]  phase_oh_reg;
  logic            phase_valid_reg;
  logic            code_err_reg;
  logic            seq_err_reg;

  logic [PW-1:0]   idx;
  logic            legal;
  logic [PW-1:0]   idx_next;

  johnson_code_check #(.N(N), .W(PW)) u_check (
    .jc    (jc_in),
    .idx   (idx),
    .legal (legal)
  );

  assign idx_next = (phase_idx_reg == LAST) ? '0 : phase_idx_reg + 1'b1;

  // Flag clears come first so a same-cycle error assignment overrides them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ACQUIRE;
      phase_idx_reg   <= '0;
      phase_oh_reg    <= '0;
      phase_valid_reg <= 1'b0;
      code_err_reg    <= 1'b0;
      seq_err_reg     <= 1'b0;
    end else begin
      if (err_clr) begin
        code_err_reg <= 1'b0;
        seq_err_reg  <= 1'b0;
      end
      case (state_reg)
        ACQUIRE: begin
          if (jc_valid) begin
            if (legal) begin
              state_reg       <= TRACK;
              phase_idx_reg   <= idx;
              phase_oh_reg    <= OH_ONE << idx;
              phase_valid_reg <= 1'b1;
            end else begin
              state_reg       <= FAULT;
              code_err_reg    <= 1'b1;
              phase_valid_reg <= 1'b0;
            end
          end
        end
        TRACK: begin
          if (jc_valid) begin
            if (!legal) begin
              state_reg       <= FAULT;
              code_err_reg    <= 1'b1;
              phase_valid_reg <= 1'b0;
            end else if (idx == phase_idx_reg || idx == idx_next) begin
              phase_idx_reg <= idx;
              phase_oh_reg  <= OH_ONE << idx;
            end else begin
              state_reg       <= FAULT;
              seq_err_reg     <= 1'b1;
              phase_valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          phase_valid_reg <= 1'b0;
          if (err_clr) begin
            state_reg <= ACQUIRE;
          end
        end
      endcase
    end
  end

  assign phase_idx   = phase_idx_reg;
  assign phase_oh    = phase_oh_reg;
  assign phase_valid = phase_valid_reg;
  assign code_err    = code_err_reg;
  assign seq_err     = seq_err_reg;

`ifdef JOHNSON_DEC_REVCNT_EN
  logic             wrap;
  logic             rev_tick_reg;
  logic [REV_W-1:0] rev_cnt_reg;

  // A wrap is an accepted 2N-1 -> 0 step while tracking.
  assign wrap = (state_reg == TRACK) && jc_valid && legal &&
                (idx == '0) && (phase_idx_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      rev_tick_reg <= 1'b0;
      rev_cnt_reg  <= '0;
    end else begin
      rev_tick_reg <= wrap;
      if (wrap) begin
        rev_cnt_reg <= rev_cnt_reg + 1'b1;
      end
    end
  end

  assign rev_tick = rev_tick_reg;
  assign rev_cnt  = rev_cnt_reg;
`else
  assign rev_tick = 1'b0;
  assign rev_cnt  = '0;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder: directed scenarios plus random
// traffic, checked against a table-driven phase model (honours JOHNSON_DEC_REVCNT_EN).
module tb_johnson_phase_decoder;

  localparam int N     = 4;
  localparam int P     = 2 * N;
  localparam int REV_W = 8;
  localparam int PW    = $clog2(P);

  logic             clk;
  logic             reset;
  logic [N-1:0]     jc_in;
  logic             jc_valid;
  logic             err_clr;
  logic [PW-1:0]    phase_idx;
  logic [P-1:0]     phase_oh;
  logic             phase_valid;
  logic             code_err;
  logic             seq_err;
  logic             rev_tick;
  logic [REV_W-1:0] rev_cnt;

  johnson_phase_decoder #(.N(N), .REV_W(REV_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .jc_in       (jc_in),
    .jc_valid    (jc_valid),
    .err_clr     (err_clr),
    .phase_idx   (phase_idx),
    .phase_oh    (phase_oh),
    .phase_valid (phase_valid),
    .code_err    (code_err),
    .seq_err     (seq_err),
    .rev_tick    (rev_tick),
    .rev_cnt     (rev_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [P-1:0] oh;
    logic         valid;
    logic         cerr;
    logic         serr;
    logic         tick;
    int           rev;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_pop   = 0;

  // Reference: the legal sequence is generated by stepping a Johnson shift register.
  logic [N-1:0] codes [P];
  int           m_mode;   // 0 acquire, 1 track, 2 fault
  int           m_idx;
  logic [P-1:0] m_oh;
  logic         m_valid, m_cerr, m_serr, m_tick;
  int           m_rev;

  function automatic int lookup(input logic [N-1:0] v);
    for (int i = 0; i < P; i++) begin
      if (codes[i] == v) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic jv, input logic [N-1:0] code,
                            input logic clr);
    int k;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_oh = '0; m_valid = 0;
      m_cerr = 0; m_serr = 0; m_tick = 0; m_rev = 0;
      return;
    end
    m_tick = 0;
    if (clr) begin
      m_cerr = 0; m_serr = 0;
    end
    k = lookup(code);
    if (m_mode == 2) begin
      m_valid = 0;
      if (clr) m_mode = 0;
    end else if (jv) begin
      if (k < 0) begin
        m_mode = 2; m_cerr = 1; m_valid = 0;
      end else if (m_mode == 0 || ((k - m_idx + P) % P) <= 1) begin
        if (m_mode == 1 && m_idx == P - 1 && k == 0) begin
          m_tick = 1;
          m_rev  = (m_rev + 1) % (1 << REV_W);
        end
        m_mode = 1; m_idx = k; m_oh = P'(1) << k; m_valid = 1;
      end else begin
        m_mode = 2; m_serr = 1; m_valid = 0;
      end
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.idx = m_idx; e.oh = m_oh; e.valid = m_valid;
    e.cerr = m_cerr; e.serr = m_serr;
`ifdef JOHNSON_DEC_REVCNT_EN
    e.tick = m_tick; e.rev = m_rev;
`else
    e.tick = 1'b0; e.rev = 0;
`endif
    return e;
  endfunction

  task automatic drive(input logic rst, input logic jv, input logic [N-1:0] code,
                       input logic clr);
    reset = rst; jc_valid = jv; jc_in = code; err_clr = clr;
    model_step(rst, jv, code, clr);
    @(posedge clk);
    #1;
    exp_q.push_back(cur_exp());
    n_push++;
  endtask

  task automatic feed(input int k);
    drive(1'b0, 1'b1, codes[k % P], 1'b0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a registered result every cycle; compare at negedge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_pop++;
      $display("[TB] t=%0t idx=%0d oh=%b v=%b ce=%b se=%b tick=%b rev=%0d",
               $time, phase_idx, phase_oh, phase_valid, code_err, seq_err, rev_tick, rev_cnt);
      check("phase_idx",   64'(phase_idx),   64'(e.idx));
      check("phase_oh",    64'(phase_oh),    64'(e.oh));
      check("phase_valid", 64'(phase_valid), 64'(e.valid));
      check("code_err",    64'(code_err),    64'(e.cerr));
      check("seq_err",     64'(seq_err),     64'(e.serr));
      check("rev_tick",    64'(rev_tick),    64'(e.tick));
      check("rev_cnt",     64'(rev_cnt),     64'(e.rev));
    end
  end

  initial begin
    logic [N-1:0] c;
    int           r;
    c = '0;
    for (int i = 0; i < P; i++) begin
      codes[i] = c;
      c = {c[N-2:0], ~c[N-1]};
    end
    model_step(1'b1, 1'b0, '0, 1'b0);

    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b1, codes[3], 1'b1);

    // One full revolution ending back at phase 0
    for (int i = 0; i <= P; i++) feed(i);

    // Hold at phase 2 for three cycles, then advance
    feed(1); feed(2); feed(2); feed(2); feed(3);

    // Illegal code, ignored legal codes in fault, then recovery
    for (int i = 4; i <= P + 1; i++) feed(i);
    drive(1'b0, 1'b1, 4'b0101, 1'b0);
    feed(2); feed(3);
    drive(1'b0, 1'b0, '0, 1'b1);
    feed(5); feed(6);

    // Skip forward, then backwards step
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    feed(2);
    feed(4);
    drive(1'b0, 1'b1, codes[2], 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    feed(2);
    feed(1);

    // Error and err_clr in the same cycle: the error wins
    drive(1'b0, 1'b0, '0, 1'b1);
    feed(0);
    drive(1'b0, 1'b1, 4'b1010, 1'b1);

    // Reset in TRACK overriding err_clr and jc_valid
    drive(1'b0, 1'b0, '0, 1'b1);
    feed(6);
    drive(1'b1, 1'b1, codes[7], 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);

    // 256 revolutions with random idle gaps: rev_cnt wraps to 0
    drive(1'b1, 1'b0, '0, 1'b0);
    feed(0);
    for (int rv = 0; rv < 256; rv++) begin
      for (int i = 1; i <= P; i++) begin
        if ($urandom_range(0, 7) == 0) drive(1'b0, 1'b0, codes[i % P], 1'b0);
        feed(i);
      end
    end

    // Random traffic mixing advance, hold, illegal/skip codes, clears and resets
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4)      c = codes[(m_idx + 1) % P];
      else if (r <= 7) c = codes[m_idx];
      else if (r == 8) c = N'($urandom);
      else             c = codes[$urandom_range(0, P - 1)];
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, c,
            $urandom_range(0, 15) == 0);
    end

    drive(1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("scoreboard_count",   64'(n_pop),        64'(n_push));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
